// File: rtl/ecc_124_err_ctrl.sv
// Error-handling controller behind the 124-bit ECC decoder: saturating counters, first-error
// capture, irq, and scrub write-back. Define ECC_SCRUB_EN to build the scrub FSM.
module ecc_124_err_ctrl #(
    parameter int unsigned DATA_WIDTH = 124,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_detc_en,
    input  logic                  cfg_bypass,
    input  logic                  cfg_irq_en,
    output logic                  ecc_fault_detc_en,
    output logic                  bypass,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic                  err_vld,
    output logic [1:0]            err_type,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  scrub_miss,
    output logic                  irq,
    output logic                  scrub_req,
    output logic [ADDR_WIDTH-1:0] scrub_addr,
    output logic [DATA_WIDTH-1:0] scrub_data,
    input  logic                  scrub_ack
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic                  detc_en_q, bypass_q, irq_q;
    logic                  qual, ev_fault, ev_dbit, ev_sbit, ev_any;
    logic [1:0]            ev_type;
    logic [CNT_WIDTH-1:0]  sbit_cnt_q, dbit_cnt_q, fault_cnt_q;
    logic [CNT_WIDTH-1:0]  sbit_cnt_d, dbit_cnt_d, fault_cnt_d;
    logic                  err_vld_q, err_vld_d;
    logic [1:0]            err_type_q, err_type_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic ev, input logic do_clr);
        logic [CNT_WIDTH-1:0] base;
        base = do_clr ? '0 : cur;
        if (ev && base != CntMax) begin
            return base + CNT_WIDTH'(1);
        end
        return base;
    endfunction

    // Status flags only count while the decoder is actually correcting.
    assign qual     = rd_vld & ~bypass_q;
    assign ev_fault = qual & ecc_fault;
    assign ev_dbit  = qual & ~ecc_fault & dbit_err;
    assign ev_sbit  = qual & ~ecc_fault & ~dbit_err & sbit_err;
    assign ev_any   = ev_fault | ev_dbit | ev_sbit;
    assign ev_type  = ev_fault ? 2'b11 : (ev_dbit ? 2'b10 : 2'b01);

    always_comb begin
        sbit_cnt_d  = cnt_next(sbit_cnt_q, ev_sbit, clr);
        dbit_cnt_d  = cnt_next(dbit_cnt_q, ev_dbit, clr);
        fault_cnt_d = cnt_next(fault_cnt_q, ev_fault, clr);
        err_vld_d   = err_vld_q & ~clr;
        err_type_d  = clr ? 2'b00 : err_type_q;
        err_addr_d  = clr ? '0 : err_addr_q;
        // A coincident event re-captures after the clear.
        if (ev_any && (!err_vld_q || clr)) begin
            err_vld_d  = 1'b1;
            err_type_d = ev_type;
            err_addr_d = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            detc_en_q   <= 1'b0;
            bypass_q    <= 1'b0;
            irq_q       <= 1'b0;
            sbit_cnt_q  <= '0;
            dbit_cnt_q  <= '0;
            fault_cnt_q <= '0;
            err_vld_q   <= 1'b0;
            err_type_q  <= 2'b00;
            err_addr_q  <= '0;
        end else begin
            detc_en_q   <= cfg_detc_en;
            bypass_q    <= cfg_bypass;
            irq_q       <= ~clr & err_vld_q & cfg_irq_en;
            sbit_cnt_q  <= sbit_cnt_d;
            dbit_cnt_q  <= dbit_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            err_vld_q   <= err_vld_d;
            err_type_q  <= err_type_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign ecc_fault_detc_en = detc_en_q;
    assign bypass            = bypass_q;
    assign irq               = irq_q;
    assign sbit_cnt          = sbit_cnt_q;
    assign dbit_cnt          = dbit_cnt_q;
    assign fault_cnt         = fault_cnt_q;
    assign err_vld           = err_vld_q;
    assign err_type          = err_type_q;
    assign err_addr          = err_addr_q;

`ifdef ECC_SCRUB_EN
    typedef enum logic [0:0] {StIdle, StReq} scrub_state_e;

    scrub_state_e          state_q, state_d;
    logic                  miss_q, miss_d, load;
    logic [ADDR_WIDTH-1:0] saddr_q;
    logic [DATA_WIDTH-1:0] sdata_q;

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q & ~clr;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_sbit) begin
                    state_d = StReq;
                    load    = 1'b1;
                end
            end
            StReq: begin
                if (ev_sbit) begin
                    miss_d = 1'b1;
                end
                if (scrub_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            miss_q  <= 1'b0;
            saddr_q <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            if (load) begin
                saddr_q <= rd_addr;
                sdata_q <= rd_data;
            end
        end
    end

    assign scrub_req  = (state_q == StReq);
    assign scrub_miss = miss_q;
    assign scrub_addr = saddr_q;
    assign scrub_data = sdata_q;
`else
    logic unused_scrub;
    assign unused_scrub = ^{scrub_ack, rd_data};

    assign scrub_req  = 1'b0;
    assign scrub_miss = 1'b0;
    assign scrub_addr = '0;
    assign scrub_data = '0;
`endif

endmodule
